bcd_time_counter: RTL

//  Parametrised BCD time counter; successor to the 4-digit MM:SS stopwatch counter.

---
 rtl/bcd_time_counter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//  Chains NUM_FIELDS two-digit BCD fields (field 0 = seconds) into a time counter
//  with up/down counting, single-field adjust, synchronous clear, pause toggle and
//  a one-cycle wrap pulse when the top field rolls over in normal mode.
//  tick / adj_tick are single-cycle enables in the clock domain, not clocks.
//  Optional feature macro: BCD_TIME_COUNTER_LAP_EN adds a lap capture register.
// Ports
//  clock, reset      system clock, asynchronous active-high reset
//  i_tick            count enable (normal mode)
//  i_adj_tick        step enable (adjust mode)
//  i_pause_btn       debounced pause level, each rising edge toggles pause
//  i_adj             1 = adjust mode, only field i_sel steps
//  i_sel             field index for adjust mode
//  i_dir             0 = up, 1 = down
//  i_clear           synchronous clear of all digits
//  i_lap             (LAP_EN) rising edge captures digits into o_lap_digits
//  o_digits          packed BCD, [3:0] field 0 units, [7:4] field 0 tens, ...
//  o_lap_digits      (LAP_EN) captured digits
//  o_paused          current pause state
//  o_wrap            top-field wrap pulse
module bcd_time_counter #(
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned LOW_MOD    = 60,
    parameter int unsigned TOP_MOD    = 60,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_tick,
    input  logic                    i_adj_tick,
    input  logic                    i_pause_btn,
    input  logic                    i_adj,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_dir,
    input  logic                    i_clear,
`ifdef BCD_TIME_COUNTER_LAP_EN
    input  logic                    i_lap,
    output logic [8*NUM_FIELDS-1:0] o_lap_digits,
`endif
    output logic [8*NUM_FIELDS-1:0] o_digits,
    output logic                    o_paused,
    output logic                    o_wrap
);

    localparam int unsigned DW = 8 * NUM_FIELDS;

    logic [DW-1:0] r_digits;
    logic          r_paused;
    logic          r_wrap;
    logic          r_pause_q;
    logic          r_pause_prev;

    logic [DW-1:0] w_next_digits;
    logic          w_wrap_next;
    logic          w_count_act;
    logic          w_adj_act;

    // Largest legal value of a field with modulus m, in BCD
    function automatic logic [7:0] f_top(input int unsigned m);
        return {4'((m - 1) / 10), 4'((m - 1) % 10)};
    endfunction

    function automatic logic f_in_range(input logic [7:0] v, input int unsigned m);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
               ((32'(v[7:4]) * 32'd10 + 32'(v[3:0])) < m);
    endfunction

    // One BCD step within modulus m; an illegal value recovers to 0
    function automatic logic [7:0] f_step(input logic [7:0] v, input logic dn,
                                          input int unsigned m);
        logic [7:0] r;
        r = 8'd0;
        if (!f_in_range(v, m)) begin
            r = 8'd0;
        end else if (!dn) begin
            if (v == f_top(m))        r = 8'd0;
            else if (v[3:0] == 4'd9)  r = {4'(v[7:4] + 4'd1), 4'd0};
            else                      r = {v[7:4], 4'(v[3:0] + 4'd1)};
        end else begin
            if (v == 8'd0)            r = f_top(m);
            else if (v[3:0] == 4'd0)  r = {4'(v[7:4] - 4'd1), 4'd9};
            else                      r = {v[7:4], 4'(v[3:0] - 4'd1)};
        end
        return r;
    endfunction

    assign w_count_act = i_tick     & ~i_adj & ~r_paused;
    assign w_adj_act   = i_adj_tick &  i_adj & ~r_paused;

    // Next digits: carry/borrow chain in normal mode, single field in adjust mode
    always_comb begin : next_state
        logic          w_carry;
        logic [7:0]    w_fld;
        int unsigned   w_mod;
        w_next_digits = r_digits;
        w_wrap_next   = 1'b0;
        w_carry       = 1'b1;
        w_fld         = 8'd0;
        w_mod         = LOW_MOD;
        for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
            w_fld = r_digits[8*k +: 8];
            w_mod = (k == NUM_FIELDS - 1) ? TOP_MOD : LOW_MOD;
            if (w_count_act && w_carry) begin
                w_next_digits[8*k +: 8] = f_step(w_fld, i_dir, w_mod);
                if ((k == NUM_FIELDS - 1) &&
                    (w_fld == (i_dir ? 8'd0 : f_top(w_mod))))
                    w_wrap_next = 1'b1;
            end
            // Higher field moves only when every lower field sits at its terminal value
            w_carry = w_carry & (i_dir ? (w_fld == 8'd0) : (w_fld == f_top(w_mod)));
            if (w_adj_act && (32'(i_sel) == k))
                w_next_digits[8*k +: 8] = f_step(w_fld, i_dir, w_mod);
        end
    end

    // Pause edge detect on the registered button level, plus counter state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_digits     <= '0;
            r_paused     <= 1'b0;
            r_wrap       <= 1'b0;
            r_pause_q    <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_pause_q    <= i_pause_btn;
            r_pause_prev <= r_pause_q;
            if (r_pause_q && !r_pause_prev)
                r_paused <= ~r_paused;
            if (i_clear) begin
                r_digits <= '0;
                r_wrap   <= 1'b0;
            end else begin
                r_digits <= w_next_digits;
                r_wrap   <= w_wrap_next;
            end
        end
    end

`ifdef BCD_TIME_COUNTER_LAP_EN
    logic          r_lap_q;
    logic          r_lap_prev;
    logic [DW-1:0] r_lap_digits;

    // Lap capture on the rising edge of the registered lap level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lap_q      <= 1'b0;
            r_lap_prev   <= 1'b0;
            r_lap_digits <= '0;
        end else begin
            r_lap_q    <= i_lap;
            r_lap_prev <= r_lap_q;
            if (i_clear)
                r_lap_digits <= '0;
            else if (r_lap_q && !r_lap_prev)
                r_lap_digits <= r_digits;
        end
    end

    assign o_lap_digits = r_lap_digits;
`endif

    assign o_digits = r_digits;
    assign o_paused = r_paused;
    assign o_wrap   = r_wrap;

endmodule
